// File: rtl/pc_alu_branch_unit.sv
// Fetch PC register plus combinational 32-bit ALU and branch decider.
// Ports: clk/reset(active-low), pc_src/stall/jump_addr -> i_addr/i_valid; A/B/alu_op -> result+flags; branch_type -> branch_taken.
module pc_alu_branch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_src,
  input  logic        stall,
  input  logic [31:0] jump_addr,
  output logic [31:0] i_addr,
  output logic        i_valid,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  alu_op,
  output logic [31:0] result,
  output logic        zero,
  output logic        neg,
  output logic        c_out,
  output logic        over,
  input  logic [2:0]  branch_type,
  output logic        branch_taken
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_addr  <= 32'h0;
      i_valid <= 1'b0;
    end else begin
      if (pc_src)
        i_addr <= jump_addr;
      else if (!stall)
        i_addr <= i_addr + 32'd4;
      i_valid <= ~stall | pc_src;
    end
  end

  logic        is_add;
  logic        is_sub;
  logic        arith;
  logic [31:0] b_eff;
  logic [32:0] sum;

  // Subtraction reuses the adder: A + ~B + 1.
  always_comb begin
    is_add = (alu_op == 3'b010);
    is_sub = (alu_op == 3'b011);
    arith  = is_add | is_sub;
    b_eff  = is_sub ? ~B : B;
    sum    = {1'b0, A} + {1'b0, b_eff} + {32'h0, is_sub};
  end

  always_comb begin
    result = B;
    unique case (alu_op)
      3'b000: result = B;
      3'b001: result = A;
      3'b010: result = sum[31:0];
      3'b011: result = sum[31:0];
      3'b100: result = A & B;
      3'b101: result = A | B;
      3'b110: result = A ^ B;
      3'b111: result = B;
      default: result = B;
    endcase
  end

  always_comb begin
    zero  = (result == 32'h0);
    neg   = result[31];
    c_out = arith & sum[32];
    over  = arith & (A[31] == b_eff[31])
                  & (sum[31] != A[31]);
  end

  always_comb begin
    branch_taken = 1'b0;
    unique case (branch_type)
      3'b000: branch_taken = zero;
      3'b001: branch_taken = ~zero;
      3'b100: branch_taken = neg ^ over;
      3'b101: branch_taken = ~(neg ^ over);
      3'b110: branch_taken = ~c_out;
      3'b111: branch_taken = c_out;
      default: branch_taken = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_pc_alu_branch_unit.sv
// Directed bench for pc_alu_branch_unit.
// Expected values are queued at stimulus time and popped at check time.
module tb_pc_alu_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_src;
  logic        stall;
  logic [31:0] jump_addr;
  logic [31:0] i_addr;
  logic        i_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  alu_op;
  logic [31:0] result;
  logic        zero;
  logic        neg;
  logic        c_out;
  logic        over;
  logic [2:0]  branch_type;
  logic        branch_taken;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  pc_alu_branch_unit dut (
    .clk(clk),
    .reset(reset),
    .pc_src(pc_src),
    .stall(stall),
    .jump_addr(jump_addr),
    .i_addr(i_addr),
    .i_valid(i_valid),
    .A(A),
    .B(B),
    .alu_op(alu_op),
    .result(result),
    .zero(zero),
    .neg(neg),
    .c_out(c_out),
    .over(over),
    .branch_type(branch_type),
    .branch_taken(branch_taken)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty: got %h required entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s: got %h required %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expect PC outputs after next edge.
  task automatic pc_edge(input string tag, input logic [31:0] a,
                         input logic v);
    push({tag, "_addr"}, a);
    push({tag, "_valid"}, {31'h0, v});
    step();
    chk(i_addr);
    chk({31'h0, i_valid});
  endtask

  // flags packed as {zero,neg,c_out,over}
  task automatic alu(input string tag, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r, input logic [3:0] f);
    alu_op = op;
    A = a;
    B = b;
    push({tag, "_res"}, r);
    push({tag, "_flags"}, {28'h0, f});
    #1;
    chk(result);
    chk({28'h0, zero, neg, c_out, over});
  endtask

  task automatic br(input string tag, input logic [2:0] bt,
                    input logic t);
    branch_type = bt;
    push(tag, {31'h0, t});
    #1;
    chk({31'h0, branch_taken});
  endtask

  initial begin
    reset = 1'b0;
    pc_src = 1'b0;
    stall = 1'b0;
    jump_addr = 32'h0;
    A = 32'h0;
    B = 32'h0;
    alu_op = 3'b000;
    branch_type = 3'b010;

    step();
    push("reset_addr", 32'h0);
    push("reset_valid", 32'h0);
    step();
    chk(i_addr);
    chk({31'h0, i_valid});

    @(negedge clk);
    reset = 1'b1;
    pc_edge("first", 32'h4, 1'b1);

    pc_src = 1'b1;
    jump_addr = 32'h40;
    pc_edge("jump40", 32'h40, 1'b1);
    pc_src = 1'b0;

    #2;
    reset = 1'b0;
    push("async_addr", 32'h0);
    push("async_valid", 32'h0);
    #1;
    chk(i_addr);
    chk({31'h0, i_valid});
    @(negedge clk);
    reset = 1'b1;
    pc_edge("rel1", 32'h4, 1'b1);
    pc_edge("rel2", 32'h8, 1'b1);
    pc_edge("rel3", 32'hC, 1'b1);

    pc_src = 1'b1;
    jump_addr = 32'h10;
    pc_edge("jump10", 32'h10, 1'b1);
    pc_src = 1'b0;
    stall = 1'b1;
    pc_edge("stall1", 32'h10, 1'b0);
    pc_edge("stall2", 32'h10, 1'b0);
    pc_src = 1'b1;
    jump_addr = 32'h100;
    pc_edge("stall_src", 32'h100, 1'b1);
    stall = 1'b0;
    jump_addr = 32'hFFFF_FFFC;
    pc_edge("jumptop", 32'hFFFF_FFFC, 1'b1);
    pc_src = 1'b0;
    pc_edge("wrap", 32'h0, 1'b1);

    alu("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'h1,
        32'h8000_0000, 4'b0101);
    alu("add_carry", 3'b010, 32'hFFFF_FFFF, 32'h1,
        32'h0, 4'b1010);
    alu("sub_eq", 3'b011, 32'h5, 32'h5, 32'h0, 4'b1010);
    br("beq_eq", 3'b000, 1'b1);
    br("bgeu_eq", 3'b111, 1'b1);
    br("none_eq", 3'b010, 1'b0);
    alu("sub_0m1", 3'b011, 32'h0, 32'h1,
        32'hFFFF_FFFF, 4'b0100);
    alu("sub_m1m1", 3'b011, 32'hFFFF_FFFF, 32'h1,
        32'hFFFF_FFFE, 4'b0110);
    br("blt", 3'b100, 1'b1);
    br("bge", 3'b101, 1'b0);
    br("bltu", 3'b110, 1'b0);
    br("bgeu", 3'b111, 1'b1);
    br("bne", 3'b001, 1'b1);
    br("beq", 3'b000, 1'b0);
    br("none", 3'b010, 1'b0);
    br("none011", 3'b011, 1'b0);
    alu("sub_ovf", 3'b011, 32'h8000_0000, 32'h1,
        32'h7FFF_FFFF, 4'b0011);
    br("blt_ovf", 3'b100, 1'b1);
    alu("and", 3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0,
        32'h00F0_00F0, 4'b0000);
    alu("or", 3'b101, 32'hF0F0_F0F0, 32'h0FF0_0FF0,
        32'hFFF0_FFF0, 4'b0100);
    alu("xor", 3'b110, 32'hF0F0_F0F0, 32'h0FF0_0FF0,
        32'hFF00_FF00, 4'b0100);
    alu("passb0", 3'b000, 32'h1234_5678, 32'h8000_0001,
        32'h8000_0001, 4'b0100);
    alu("passa", 3'b001, 32'h1234_5678, 32'h0,
        32'h1234_5678, 4'b0000);
    alu("passb7", 3'b111, 32'hFFFF_FFFF, 32'h0,
        32'h0, 4'b1000);

    if (sb.size() != 0) begin
      failures++;
      $error("FAIL scoreboard_leftover: got %0d required 0",
             sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
